// File: rtl/ws2812_pkg.sv
// Shared types and sizing helpers for the WS2812 frame scheduler.
package ws2812_pkg;

    localparam int unsigned BYTES_PER_LED = 3;
    localparam int unsigned BITS_PER_BYTE = 8;
    localparam int unsigned BIT_IDX_W     = $clog2(BITS_PER_BYTE);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_SHIFT,
        ST_LATCH
    } state_e;

    // Byte counter width: must hold BYTES_PER_LED * max_leds without wrapping.
    function automatic int unsigned byte_cnt_width(input int unsigned max_leds);
        return (max_leds == 0) ? 1 : $clog2(BYTES_PER_LED * max_leds);
    endfunction

    // Down-counter width able to hold cycles-1.
    function automatic int unsigned timer_width(input int unsigned cycles);
        return (cycles <= 2) ? 1 : $clog2(cycles);
    endfunction

endpackage

// File: rtl/ws2812_frame_scheduler_if.sv
// Pixel-byte input stream, serial bit output stream and frame status.
interface ws2812_frame_scheduler_if;
    import ws2812_pkg::*;

    logic [7:0]               num_leds;
    logic                     in_valid;
    logic [BITS_PER_BYTE-1:0] in_data;
    logic                     in_ready;
    logic                     bit_valid;
    logic                     bit_data;
    logic                     bit_ready;
    logic                     busy;
    logic                     frame_done;
    logic                     abort;

    modport master (
        output num_leds, in_valid, in_data, bit_ready,
        input  in_ready, bit_valid, bit_data, busy, frame_done, abort
    );

    modport slave (
        input  num_leds, in_valid, in_data, bit_ready,
        output in_ready, bit_valid, bit_data, busy, frame_done, abort
    );

endinterface

// File: rtl/ws2812_gap_timer.sv
// Loadable down-counter with a registered zero flag; holds at zero.
module ws2812_gap_timer #(
    parameter int unsigned WIDTH = 12
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             dec,
    output logic             zero
);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    // Next count: load wins over decrement, no underflow.
    always_comb begin
        count_d = count_q;
        if (load) begin
            count_d = load_val;
        end else if (dec && (count_q != '0)) begin
            count_d = count_q - WIDTH'(1);
        end
    end

    // Counter and zero flag registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
            zero    <= 1'b1;
        end else begin
            count_q <= count_d;
            zero    <= (count_d == '0);
        end
    end

endmodule

// File: rtl/ws2812_frame_scheduler.sv
// Serialises G,R,B pixel bytes MSB-first toward a WS2812 symbol encoder and
// inserts the reset/latch low gap after each frame.
// Optional feature: define WS2812_FRAME_TIMEOUT_EN to abort a frame whose
// byte stream starves mid-frame for TIMEOUT_CYCLES clocks.
module ws2812_frame_scheduler
    import ws2812_pkg::*;
#(
    parameter int unsigned MAX_LEDS       = 255,
    parameter int unsigned LATCH_CYCLES   = 3000,
    parameter int unsigned TIMEOUT_CYCLES = 65535
) (
    input  logic                  clk,
    input  logic                  rst,
    ws2812_frame_scheduler_if.slave bus
);

    localparam int unsigned CNT_W = byte_cnt_width(MAX_LEDS);
`ifdef WS2812_FRAME_TIMEOUT_EN
    localparam int unsigned TMR_W = timer_width((LATCH_CYCLES > TIMEOUT_CYCLES) ?
                                                LATCH_CYCLES : TIMEOUT_CYCLES);
    localparam logic [TMR_W-1:0] TIMEOUT_LOAD = TMR_W'(TIMEOUT_CYCLES - 1);
`else
    localparam int unsigned TMR_W = timer_width(LATCH_CYCLES);
`endif
    localparam logic [TMR_W-1:0] LATCH_LOAD = TMR_W'(LATCH_CYCLES - 1);

    // Zero-length gaps would underflow the timer load values.
    if (LATCH_CYCLES == 0 || TIMEOUT_CYCLES == 0) begin : g_bad_params
        $error("ws2812_frame_scheduler: LATCH_CYCLES and TIMEOUT_CYCLES must be nonzero");
    end

    state_e                   state_q, state_d;
    logic [BITS_PER_BYTE-1:0] shift_q, shift_d;
    logic [BIT_IDX_W-1:0]     idx_q, idx_d;
    logic [CNT_W-1:0]         byte_cnt_q, byte_cnt_d;
    logic [CNT_W-1:0]         frame_len_q, frame_len_d;
    logic                     armed_q;
    logic [7:0]               leds_clamped;
    logic                     frame_done_d;
    logic                     abort_d;
    logic                     tmr_load;
    logic                     tmr_dec;
    logic [TMR_W-1:0]         tmr_load_val;
    logic                     tmr_zero;

    // Shared down-counter: latch gap in LATCH, starvation timer in LOAD.
    ws2812_gap_timer #(
        .WIDTH(TMR_W)
    ) u_gap_timer (
        .clk     (clk),
        .rst     (rst),
        .load    (tmr_load),
        .load_val(tmr_load_val),
        .dec     (tmr_dec),
        .zero    (tmr_zero)
    );

    // Next-state, datapath and pulse decode.
    always_comb begin
        state_d      = state_q;
        shift_d      = shift_q;
        idx_d        = idx_q;
        byte_cnt_d   = byte_cnt_q;
        frame_len_d  = frame_len_q;
        frame_done_d = 1'b0;
        abort_d      = 1'b0;
        tmr_load     = 1'b0;
        tmr_dec      = 1'b0;
        tmr_load_val = '0;
        leds_clamped = (32'(bus.num_leds) > MAX_LEDS) ? 8'(MAX_LEDS) : bus.num_leds;

        case (state_q)
            ST_IDLE: begin
                byte_cnt_d = '0;
                // armed_q holds off the first LOAD until the second edge after reset.
                if (armed_q && (bus.num_leds != 8'd0)) begin
                    state_d     = ST_LOAD;
                    frame_len_d = CNT_W'(BYTES_PER_LED * 32'(leds_clamped));
                end
            end
            ST_LOAD: begin
                if (bus.in_valid) begin
                    shift_d = bus.in_data;
                    idx_d   = BIT_IDX_W'(BITS_PER_BYTE - 1);
                    state_d = ST_SHIFT;
                end
`ifdef WS2812_FRAME_TIMEOUT_EN
                else if (byte_cnt_q != '0) begin
                    if (tmr_zero) begin
                        abort_d      = 1'b1;
                        state_d      = ST_LATCH;
                        tmr_load     = 1'b1;
                        tmr_load_val = LATCH_LOAD;
                    end else begin
                        tmr_dec = 1'b1;
                    end
                end
`endif
            end
            ST_SHIFT: begin
                if (bus.bit_ready) begin
                    // Rotate so every register bit stays live; MSB is the next bit out.
                    shift_d = {shift_q[BITS_PER_BYTE-2:0], shift_q[BITS_PER_BYTE-1]};
                    idx_d   = idx_q - BIT_IDX_W'(1);
                    if (idx_q == '0) begin
                        byte_cnt_d = byte_cnt_q + CNT_W'(1);
                        if ((byte_cnt_q + CNT_W'(1)) == frame_len_q) begin
                            state_d      = ST_LATCH;
                            tmr_load     = 1'b1;
                            tmr_load_val = LATCH_LOAD;
                        end else begin
                            state_d = ST_LOAD;
`ifdef WS2812_FRAME_TIMEOUT_EN
                            tmr_load     = 1'b1;
                            tmr_load_val = TIMEOUT_LOAD;
`endif
                        end
                    end
                end
            end
            ST_LATCH: begin
                if (tmr_zero) begin
                    frame_done_d = 1'b1;
                    byte_cnt_d   = '0;
                    state_d      = ST_IDLE;
                end else begin
                    tmr_dec = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State, datapath and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= ST_IDLE;
            shift_q        <= '0;
            idx_q          <= '0;
            byte_cnt_q     <= '0;
            frame_len_q    <= '0;
            armed_q        <= 1'b0;
            bus.in_ready   <= 1'b0;
            bus.bit_valid  <= 1'b0;
            bus.bit_data   <= 1'b0;
            bus.busy       <= 1'b0;
            bus.frame_done <= 1'b0;
            bus.abort      <= 1'b0;
        end else begin
            state_q        <= state_d;
            shift_q        <= shift_d;
            idx_q          <= idx_d;
            byte_cnt_q     <= byte_cnt_d;
            frame_len_q    <= frame_len_d;
            armed_q        <= 1'b1;
            bus.in_ready   <= (state_d == ST_LOAD);
            bus.bit_valid  <= (state_d == ST_SHIFT);
            bus.bit_data   <= (state_d == ST_SHIFT) && shift_d[BITS_PER_BYTE-1];
            bus.busy       <= (state_d != ST_IDLE);
            bus.frame_done <= frame_done_d;
            bus.abort      <= abort_d;
        end
    end

endmodule

// File: tb/tb_ws2812_frame_scheduler.sv
// Scoreboard bench for ws2812_frame_scheduler: stimulus queues expected bits,
// frame and abort events; a negedge monitor pops and compares.
module tb_ws2812_frame_scheduler;

    localparam int LATCH = 20;
    localparam int TMO   = 16;
    localparam int BOUND = 2000;

    logic clk = 1'b0;
    logic rst = 1'b1;

    ws2812_frame_scheduler_if bus ();

    ws2812_frame_scheduler #(
        .MAX_LEDS      (255),
        .LATCH_CYCLES  (LATCH),
        .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    int passed = 0;
    int total  = 0;

    bit exp_bits[$];
    bit frame_q[$];
    bit abort_q[$];

    int cyc = 0;
    int last_acc_edge = 0;
    int bits_acc = 0;
    int bytes_acc = 0;
    int frames_seen = 0;
    int aborts_seen = 0;
    bit prev_stall = 1'b0;
    bit prev_bit = 1'b0;
    bit bp_mode = 1'b0;
    int bp_phase = 0;

    function automatic void check(input string name, input int act, input int exp);
        total++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    // bit_ready driver: steady 1, or repeating 1-0-0-1 during backpressure.
    always @(posedge clk) begin
        #1;
        if (bp_mode) begin
            bus.bit_ready = (bp_phase == 0 || bp_phase == 3);
            bp_phase = (bp_phase + 1) % 4;
        end else begin
            bus.bit_ready = 1'b1;
            bp_phase = 0;
        end
    end

    // Monitor: compare everything the DUT presents against the scoreboard.
    always @(negedge clk) begin
        bit e;
        if (rst) begin
            prev_stall = 1'b0;
        end else begin
            if (bus.bit_valid) check("in_ready_low_in_shift", bus.in_ready, 0);
            if (prev_stall) check("stall_hold", {bus.bit_valid, bus.bit_data}, {1'b1, prev_bit});
            if (bus.in_valid && bus.in_ready) bytes_acc++;
            if (bus.bit_valid && bus.bit_ready) begin
                bits_acc++;
                last_acc_edge = cyc + 1;
                if (exp_bits.size() == 0) begin
                    check("unexpected_bit", 1, 0);
                end else begin
                    e = exp_bits.pop_front();
                    check("bit_data", bus.bit_data, e);
                end
            end
            prev_stall = bus.bit_valid && !bus.bit_ready;
            prev_bit   = bus.bit_data;
            if (bus.abort) begin
                aborts_seen++;
                if (abort_q.size() == 0) begin
                    check("unexpected_abort", 1, 0);
                end else begin
                    void'(abort_q.pop_front());
                    check("abort_gap", cyc - last_acc_edge, TMO);
                end
                last_acc_edge = cyc;
            end
            if (bus.frame_done) begin
                frames_seen++;
                if (frame_q.size() == 0) begin
                    check("unexpected_frame_done", 1, 0);
                end else begin
                    void'(frame_q.pop_front());
                    check("frame_gap", cyc - last_acc_edge, LATCH);
                    check("busy_low_at_done", bus.busy, 0);
                end
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Offer one byte and return one cycle after it is accepted.
    task automatic send_byte(input logic [7:0] b);
        int n = 0;
        for (int i = 7; i >= 0; i--) exp_bits.push_back(b[i]);
        bus.in_valid = 1'b1;
        bus.in_data  = b;
        while (!bus.in_ready && n < BOUND) begin
            tick(1);
            n++;
        end
        if (n >= BOUND) begin
            check("send_byte_timeout", 1, 0);
        end else begin
            tick(1);
        end
        bus.in_valid = 1'b0;
    endtask

    task automatic wait_frame(input int target);
        int n = 0;
        while (frames_seen < target && n < BOUND) begin
            tick(1);
            n++;
        end
        check("frame_done_count", frames_seen, target);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1);
    end

    initial begin
        int viol;
        int b0;
        int by0;
        int tgt;
        int n;
        bus.num_leds = 8'd0;
        bus.in_valid = 1'b0;
        bus.in_data  = 8'd0;

        // Reset values
        tick(3);
        check("rst_in_ready", bus.in_ready, 0);
        check("rst_bit_valid", bus.bit_valid, 0);
        check("rst_bit_data", bus.bit_data, 0);
        check("rst_busy", bus.busy, 0);
        check("rst_frame_done", bus.frame_done, 0);
        check("rst_abort", bus.abort, 0);
        rst = 1'b0;

        // num_leds == 0 keeps the block idle
        viol = 0;
        for (int i = 0; i < 1000; i++) begin
            tick(1);
            if (bus.busy || bus.in_ready) viol++;
        end
        check("zero_leds_idle", viol, 0);

        // One LED, bytes A5 00 FF, num_leds dropped mid-frame
        tgt = frames_seen + 1;
        b0 = bits_acc;
        frame_q.push_back(1'b1);
        bus.num_leds = 8'd1;
        send_byte(8'hA5);
        bus.num_leds = 8'd0;
        send_byte(8'h00);
        send_byte(8'hFF);
        wait_frame(tgt);
        check("frame1_bits", bits_acc - b0, 24);
        tick(3);
        check("frame1_idle_busy", bus.busy, 0);
        check("frame1_idle_in_ready", bus.in_ready, 0);

        // Backpressure 1-0-0-1 over a two-LED frame
        bp_mode = 1'b1;
        tgt = frames_seen + 1;
        b0 = bits_acc;
        frame_q.push_back(1'b1);
        bus.num_leds = 8'd2;
        send_byte(8'h3C);
        bus.num_leds = 8'd0;
        send_byte(8'hC3);
        send_byte(8'h81);
        send_byte(8'h7E);
        send_byte(8'h55);
        send_byte(8'hAA);
        wait_frame(tgt);
        check("bp_bits", bits_acc - b0, 48);
        bp_mode = 1'b0;
        tick(3);

        // Reset after 11 bits, then a fresh frame from byte 0
        frame_q.push_back(1'b1);
        b0 = bits_acc;
        bus.num_leds = 8'd1;
        send_byte(8'hF0);
        send_byte(8'h0F);
        n = 0;
        while ((bits_acc - b0) < 11 && n < BOUND) begin
            tick(1);
            n++;
        end
        check("bits_before_reset", bits_acc - b0, 11);
        rst = 1'b1;
        #1;
        check("async_rst_bit_valid", bus.bit_valid, 0);
        check("async_rst_busy", bus.busy, 0);
        check("async_rst_in_ready", bus.in_ready, 0);
        exp_bits.delete();
        frame_q.delete();
        tick(2);
        rst = 1'b0;
        tick(1);
        check("no_load_first_edge", bus.in_ready, 0);
        tgt = frames_seen + 1;
        b0 = bits_acc;
        frame_q.push_back(1'b1);
        send_byte(8'h80);
        bus.num_leds = 8'd0;
        send_byte(8'h01);
        send_byte(8'hC3);
        wait_frame(tgt);
        check("restart_bits", bits_acc - b0, 24);
        tick(3);

        // Full 255-LED frame
        tgt = frames_seen + 1;
        by0 = bytes_acc;
        frame_q.push_back(1'b1);
        bus.num_leds = 8'd255;
        for (int i = 0; i < 765; i++) begin
            send_byte(8'(i * 7 + 3));
            if (i == 0) bus.num_leds = 8'd0;
        end
        wait_frame(tgt);
        check("max_bytes", bytes_acc - by0, 765);
        tick(LATCH + 20);
        check("max_single_frame_done", frames_seen, tgt);
        check("max_idle_busy", bus.busy, 0);

`ifdef WS2812_FRAME_TIMEOUT_EN
        // Starve after 4 of 6 bytes
        tgt = frames_seen + 1;
        by0 = bytes_acc;
        abort_q.push_back(1'b1);
        frame_q.push_back(1'b1);
        bus.num_leds = 8'd2;
        send_byte(8'h11);
        bus.num_leds = 8'd0;
        send_byte(8'h22);
        send_byte(8'h33);
        send_byte(8'h44);
        n = 0;
        while (aborts_seen < 1 && n < BOUND) begin
            tick(1);
            n++;
        end
        check("abort_count", aborts_seen, 1);
        wait_frame(tgt);
        check("timeout_bytes", bytes_acc - by0, 4);
        tick(3);
`else
        check("abort_never", aborts_seen, 0);
`endif

        check("bits_drained", exp_bits.size(), 0);
        check("frames_drained", frame_q.size(), 0);
        check("aborts_drained", abort_q.size(), 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
